// File: rtl/bank_rd_scheduler.sv
// Read scheduler for a 4-bank memory: arbitrates two requesters, issues one-hot bank reads,
// and aligns the output-mux select with returning data. Define RR_ARB_EN for round-robin arbitration.
module bank_rd_scheduler #(
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [1:0]            i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    output logic [1:0]            o_gnt,
    output logic [3:0]            o_bank_en,
    output logic [ADDR_WIDTH-3:0] o_bank_addr,
    output logic [1:0]            o_mux_sel,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_id,
    output logic                  o_busy
);

    localparam int BA_W = ADDR_WIDTH - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SERVE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  ptr;
    logic [1:0]            gnt;
    logic                  acc;
    logic                  gnt_id;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [1:0]            gnt_bank;
    logic                  inflight_nxt;
    logic                  any_vld;

    logic                  vld_p0;
    logic [1:0]            sel_p0;
    logic                  id_p0;
    logic [3:0]            bank_en_p0;
    logic [BA_W-1:0]       bank_addr_p0;

    logic                  vld_pn [RD_LATENCY];
    logic [1:0]            sel_pn [RD_LATENCY];
    logic                  id_pn  [RD_LATENCY];

    // Arbitration: ptr names the winner only when both requesters are active
    always_comb begin
        gnt = 2'b00;
        if (state == ST_SERVE) begin
            if (i_req == 2'b11) begin
                gnt = ptr ? 2'b10 : 2'b01;
            end else begin
                gnt = i_req;
            end
        end
    end

    assign acc      = |(i_req & gnt);
    assign gnt_id   = gnt[1];
    assign gnt_addr = gnt_id ? i_addr1 : i_addr0;
    assign gnt_bank = gnt_addr[ADDR_WIDTH-1 -: 2];

`ifdef RR_ARB_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= 1'b0;
        end else if (acc) begin
            ptr <= ~gnt_id;
        end
    end
`else
    assign ptr = 1'b0;
`endif

    // Stage p0: issue register driving the bank array
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0       <= 1'b0;
            sel_p0       <= 2'b00;
            id_p0        <= 1'b0;
            bank_en_p0   <= 4'b0000;
            bank_addr_p0 <= '0;
        end else begin
            vld_p0     <= acc;
            bank_en_p0 <= acc ? (4'b0001 << gnt_bank) : 4'b0000;
            if (acc) begin
                sel_p0       <= gnt_bank;
                id_p0        <= gnt_id;
                bank_addr_p0 <= gnt_addr[BA_W-1:0];
            end
        end
    end

    // Stages pn: latency-matching shift; sel/id only advance with a valid entry so the
    // last stage holds its value between responses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_pn[i] <= 1'b0;
                sel_pn[i] <= 2'b00;
                id_pn[i]  <= 1'b0;
            end
        end else begin
            vld_pn[0] <= vld_p0;
            if (vld_p0) begin
                sel_pn[0] <= sel_p0;
                id_pn[0]  <= id_p0;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pn[i] <= vld_pn[i-1];
                if (vld_pn[i-1]) begin
                    sel_pn[i] <= sel_pn[i-1];
                    id_pn[i]  <= id_pn[i-1];
                end
            end
        end
    end

    // The entry in the last stage is leaving this cycle, so it does not keep DRAIN alive
    always_comb begin
        inflight_nxt = vld_p0;
        any_vld      = vld_p0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            any_vld = any_vld | vld_pn[i];
            if (i < RD_LATENCY - 1) begin
                inflight_nxt = inflight_nxt | vld_pn[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_en) state_nxt = ST_SERVE;
            ST_SERVE: if (!i_en) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!inflight_nxt) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign o_gnt       = gnt;
    assign o_bank_en   = bank_en_p0;
    assign o_bank_addr = bank_addr_p0;
    assign o_mux_sel   = sel_pn[RD_LATENCY-1];
    assign o_rsp_valid = vld_pn[RD_LATENCY-1];
    assign o_rsp_id    = id_pn[RD_LATENCY-1];
    assign o_busy      = (state != ST_IDLE) | any_vld;

endmodule
